// File: rtl/uart_word_tx.sv
// uart_word_tx: word-wide UART transmitter.
// Accepts one WordBytes*DataWidth word per valid/ready handshake and sends it
// as back-to-back frames, least-significant byte first, using an internal
// bit-period down-counter.
// Optional feature macro: UART_WORD_TX_PARITY_EN (adds an even-parity bit per frame).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line high, ready for a new word
// START  | start bit (line low) for one bit period
// DATA   | payload bits, LSB first, one bit period each
// PARITY | even-parity bit (only with UART_WORD_TX_PARITY_EN)
// STOP   | stop bit (line high); next byte's START or back to IDLE
module uart_word_tx #(
    parameter int DataWidth  = 8,
    parameter int WordBytes  = 4,
    parameter int ClksPerBit = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_ni,
    input  logic [WordBytes*DataWidth-1:0] data_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    output logic                           tx_data_o,
    output logic                           busy_o
);

    localparam int TW = (ClksPerBit > 2) ? $clog2(ClksPerBit) : 1;
    localparam int BW = (DataWidth  > 2) ? $clog2(DataWidth)  : 1;
    localparam int YW = (WordBytes  > 2) ? $clog2(WordBytes)  : 1;
    localparam int SW = WordBytes * DataWidth;

    localparam logic [TW-1:0] TimerLoad = TW'(ClksPerBit - 1);
    localparam logic [BW-1:0] LastBit   = BW'(DataWidth - 1);
    localparam logic [YW-1:0] LastByte  = YW'(WordBytes - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_WORD_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [BW-1:0]   bit_idx_q, bit_idx_d;
    logic [YW-1:0]   byte_idx_q, byte_idx_d;
    logic [SW-1:0]   shift_q, shift_d;
    logic            tx_q, tx_d;
`ifdef UART_WORD_TX_PARITY_EN
    logic            par_q, par_d;
`endif

    logic accept;
    logic bit_done;

    assign accept   = valid_i & ready_o;
    assign bit_done = (timer_q == '0);

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every non-idle state lasts until the bit timer expires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = START;
            end
            START: begin
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                if (bit_done && (bit_idx_q == LastBit)) begin
`ifdef UART_WORD_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_WORD_TX_PARITY_EN
            PARITY: begin
                if (bit_done) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_done) state_d = (byte_idx_q == LastByte) ? IDLE : START;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: handshake flags from state, line level fed to the tx flop.
    always_comb begin
        ready_o = 1'b0;
        busy_o  = 1'b0;
        tx_d    = 1'b1;
        if (reset_ni) begin
            ready_o = (state_q == IDLE);
            busy_o  = (state_q != IDLE);
        end
        case (state_q)
            IDLE:   tx_d = 1'b1;
            START:  tx_d = 1'b0;
            DATA:   tx_d = shift_q[0];
`ifdef UART_WORD_TX_PARITY_EN
            PARITY: tx_d = par_q;
`endif
            STOP:   tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // Datapath next values: bit timer, indices, payload shifter, parity.
    always_comb begin
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
`ifdef UART_WORD_TX_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (accept) begin
                    timer_d    = TimerLoad;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                    shift_d    = data_i;
                end
            end
            START: begin
                if (bit_done) begin
                    timer_d   = TimerLoad;
                    bit_idx_d = '0;
`ifdef UART_WORD_TX_PARITY_EN
                    par_d     = 1'b0;
`endif
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    // Shifting one bit per data period leaves the next byte at
                    // the bottom of the shifter when this byte is finished.
                    timer_d   = TimerLoad;
                    shift_d   = shift_q >> 1;
                    bit_idx_d = (bit_idx_q == LastBit) ? '0 : bit_idx_q + 1'b1;
`ifdef UART_WORD_TX_PARITY_EN
                    par_d     = par_q ^ shift_q[0];
`endif
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`ifdef UART_WORD_TX_PARITY_EN
            PARITY: begin
                timer_d = bit_done ? TimerLoad : timer_q - 1'b1;
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (byte_idx_q == LastByte) begin
                        timer_d    = '0;
                        byte_idx_d = '0;
                    end else begin
                        timer_d    = TimerLoad;
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: timer_d = '0;
        endcase
    end

    // Datapath registers; the line flop lags the state by one cycle so it never glitches.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            timer_q    <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
`ifdef UART_WORD_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
`ifdef UART_WORD_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign tx_data_o = tx_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx with DataWidth=8, WordBytes=2, ClksPerBit=4.
module tb_uart_word_tx;

    localparam int CPB = 4;
    localparam int WB  = 2;
    localparam int DW  = 8;
`ifdef UART_WORD_TX_PARITY_EN
    localparam int FBITS = 11;
`else
    localparam int FBITS = 10;
`endif
    localparam int F = FBITS * CPB;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          valid   = 1'b0;
    logic [15:0]   data    = 16'h0000;
    logic          ready;
    logic          tx;
    logic          busy;

    int total = 0;
    int bad   = 0;

    uart_word_tx #(
        .DataWidth (DW),
        .WordBytes (WB),
        .ClksPerBit(CPB)
    ) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .data_i   (data),
        .valid_i  (valid),
        .ready_o  (ready),
        .tx_data_o(tx),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for frame bit position bitn of byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int bitn);
        if (bitn == 0) return 1'b0;
        if (bitn <= 8) return b[bitn-1];
        if (bitn == 9 && FBITS == 11) return ^b;
        return 1'b1;
    endfunction

    // Offer word w, then follow the line cycle by cycle for the whole word.
    // With hold set, valid stays high and data switches to nxt after the accept.
    task automatic tx_word(input logic [15:0] w, input bit hold, input logic [15:0] nxt);
        logic [7:0] rx;
        logic [7:0] byt;
        int k, pos, bitn, ph;
        data  = w;
        valid = 1'b1;
        chk("ready_before_accept", ready, 1);
        @(posedge clk); #1;
        if (hold) data = nxt;
        else begin
            valid = 1'b0;
            data  = ~w;
        end
        chk("idle_gap_at_accept", tx, 1);
        chk("busy_after_accept", busy, 1);
        chk("ready_after_accept", ready, 0);
        rx = 8'h00;
        for (int cyc = 1; cyc <= WB*F; cyc++) begin
            @(posedge clk); #1;
            k    = (cyc - 1) / F;
            pos  = (cyc - 1) % F;
            bitn = pos / CPB;
            ph   = pos % CPB;
            byt  = w[k*8 +: 8];
            chk("line", tx, exp_bit(byt, bitn));
            if (ph == 2 && bitn >= 1 && bitn <= 8) rx[bitn-1] = tx;
            if (pos == F - 1) begin
                chk("rx_byte", rx, byt);
                rx = 8'h00;
            end
            chk("ready_during_word", ready, (cyc == WB*F) ? 1 : 0);
        end
    endtask

    initial begin
        // Reset held for a few edges.
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", tx, 1);
        chk("reset_ready", ready, 0);
        chk("reset_busy", busy, 0);
        reset_n = 1'b1;
        #1;
        chk("release_ready", ready, 1);

        // Idle for 100 cycles with valid low.
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            chk("idle_tx", tx, 1);
            chk("idle_ready", ready, 1);
            chk("idle_busy", busy, 0);
        end

        // Single word.
        tx_word(16'hA55A, 1'b0, 16'h0000);

        // Back-to-back with valid held high; second word waits for ready.
        tx_word(16'h1234, 1'b1, 16'h5678);
        tx_word(16'h5678, 1'b0, 16'h0000);

        // Reset at cycle 20 of a word (line low on data bit 3 of 0xA5).
        @(posedge clk); #1;
        data  = 16'h5AA5;
        valid = 1'b1;
        chk("ready_before_abort_word", ready, 1);
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("line_before_reset", tx, 0);
        chk("busy_before_reset", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("busy_in_reset", busy, 0);
        chk("ready_in_reset", ready, 0);
        @(posedge clk); #1;
        chk("tx_after_reset_edge", tx, 1);
        chk("busy_after_reset_edge", busy, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        chk("ready_after_release", ready, 1);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            chk("no_resume_tx", tx, 1);
            chk("no_resume_busy", busy, 0);
        end
        tx_word(16'h00FF, 1'b0, 16'h0000);

`ifdef UART_WORD_TX_PARITY_EN
        tx_word(16'h0701, 1'b0, 16'h0000);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("final_idle_tx", tx, 1);
        chk("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
